// File: rtl/cmp_serial_pkg.sv
// Shared op encodings, FSM states and helpers for the chunk-serial integer comparator.
package cmp_serial_pkg;

  localparam logic [1:0] CMP_OP_LT = 2'b00;
  localparam logic [1:0] CMP_OP_LE = 2'b01;
  localparam logic [1:0] CMP_OP_EQ = 2'b10;
  localparam logic [1:0] CMP_OP_NE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } cmp_state_t;

  // Chunk counter width; never narrower than one bit.
  function automatic int cnt_width(input int nch);
    return (nch > 2) ? $clog2(nch) : 1;
  endfunction

  function automatic logic cmp_result(input logic [1:0] op, input logic decided,
                                      input logic lt);
    logic r;
    r = 1'b0;
    case (op)
      CMP_OP_LT: r = lt;
      CMP_OP_LE: r = lt | ~decided;
      CMP_OP_EQ: r = ~decided;
      CMP_OP_NE: r = decided;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_chunk_uint.sv
// Combinational DIGIT-bit unsigned compare; zero latency, no flow control.
// IMPL_TYPE 0 uses the relational operator, any other value an MSB-first bit scan.
module cmp_chunk_uint #(
  parameter int DIGIT     = 4,
  parameter int IMPL_TYPE = 0
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             chunk_lt,
  output logic             chunk_eq
);

  if (IMPL_TYPE == 0) begin : g_rel
    assign chunk_lt = (a < b);
    assign chunk_eq = (a == b);
  end else begin : g_scan
    always_comb begin
      chunk_lt = 1'b0;
      chunk_eq = 1'b1;
      for (int i = DIGIT - 1; i >= 0; i--) begin
        if (chunk_eq && (a[i] != b[i])) begin
          chunk_lt = b[i];
          chunk_eq = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/cmp_int_serial.sv
// Chunk-serial signed/unsigned LT/LE/EQ/NE comparator, MSB chunk first, NCH+1 cycle latency
// (first-difference exit with CMP_SERIAL_EARLY_EXIT_EN); single request in flight, result held under out_ready=0.
module cmp_int_serial
  import cmp_serial_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIGIT     = 4,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y
);

  localparam int NCH = WIDTH / DIGIT;
  localparam int CW  = cnt_width(NCH);

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_cfg
    $error("cmp_int_serial: WIDTH must be a multiple of DIGIT and at least 2");
  end

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             decided_q, lt_q, y_q;
  logic             chunk_lt, chunk_eq;
  logic             decided_d, lt_d, last, run_exit;
  logic [WIDTH-1:0] sign_flip;

  // Operands shift left each RUN cycle, so the top DIGIT bits are always chunk cnt.
  cmp_chunk_uint #(.DIGIT(DIGIT), .IMPL_TYPE(IMPL_TYPE)) u_chunk (
    .a        (a_q[WIDTH-1 -: DIGIT]),
    .b        (b_q[WIDTH-1 -: DIGIT]),
    .chunk_lt (chunk_lt),
    .chunk_eq (chunk_eq)
  );

  assign sign_flip = {is_signed, {(WIDTH-1){1'b0}}};
  assign decided_d = decided_q | ~chunk_eq;
  assign lt_d      = decided_q ? lt_q : (~chunk_eq & chunk_lt);
  assign last      = (cnt_q == CW'(NCH - 1));

`ifdef CMP_SERIAL_EARLY_EXIT_EN
  assign run_exit = last | ~chunk_eq;
`else
  assign run_exit = last;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (run_exit) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= CMP_OP_LT;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      lt_q      <= 1'b0;
      y_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            // Inverting the sign bit maps two's-complement order onto unsigned order.
            a_q       <= a ^ sign_flip;
            b_q       <= b ^ sign_flip;
            op_q      <= op;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
          end
        end
        ST_RUN: begin
          a_q       <= a_q << DIGIT;
          b_q       <= b_q << DIGIT;
          cnt_q     <= cnt_q + CW'(1);
          decided_q <= decided_d;
          lt_q      <= lt_d;
          if (run_exit) y_q <= cmp_result(op_q, decided_d, lt_d);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign out_valid = (state_q == ST_DONE);
  assign y         = y_q;

endmodule

// File: tb/tb_cmp_int_serial.sv
module tb_cmp_int_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       is_signed;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic       y;

  int n_pass = 0;
  int n_fail = 0;

  cmp_int_serial #(.WIDTH(8), .DIGIT(2), .IMPL_TYPE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer comparison of the operands as numbers.
  function automatic logic ref_y(input logic [7:0] ra, input logic [7:0] rb,
                                 input logic rs, input logic [1:0] rop);
    int va, vb;
    va = rs ? int'($signed(ra)) : int'(ra);
    vb = rs ? int'($signed(rb)) : int'(rb);
    case (rop)
      2'b00:   return va <  vb;
      2'b01:   return va <= vb;
      2'b10:   return va == vb;
      default: return va != vb;
    endcase
  endfunction

  // Cycle (after the accept edge) in which out_valid first appears.
  function automatic int ref_lat(input logic [7:0] ra, input logic [7:0] rb);
`ifdef CMP_SERIAL_EARLY_EXIT_EN
    for (int k = 0; k < 4; k++)
      if (((int'(ra) >> (6 - 2*k)) & 3) != ((int'(rb) >> (6 - 2*k)) & 3)) return k + 2;
`endif
    return (ra == rb) ? 5 : 5;
  endfunction

  task automatic run_req(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                         input logic [1:0] top, input string tag);
    logic ey;
    int   el, cyc;
    ey = ref_y(ta, tb, ts, top);
    el = ref_lat(ta, tb);
    a = ta; b = tb; is_signed = ts; op = top; in_valid = 1'b1;
    chk(32'(in_ready), 32'd1, {tag, " in_ready idle"});
    step();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); is_signed = 1'($urandom);
    cyc = 1;
    chk(32'(in_ready), 32'd0, {tag, " in_ready busy"});
    while (!out_valid && cyc < 30) begin
      step();
      cyc++;
    end
    chk(32'(out_valid), 32'd1, {tag, " out_valid"});
    chk(32'(cyc), 32'(el), {tag, " latency"});
    chk(32'(y), 32'(ey), {tag, " y"});
    step();
    chk(32'(out_valid), 32'd0, {tag, " out_valid after accept"});
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       held_y;
    int         cyc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; op = 2'b00;
    out_ready = 1'b1;
    step();
    step();
    chk(32'(in_ready), 32'd0, "reset in_ready");
    chk(32'(out_valid), 32'd0, "reset out_valid");
    chk(32'(y), 32'd0, "reset y");
    rst = 1'b0;
    step();
    chk(32'(in_ready), 32'd1, "in_ready after reset");

    run_req(8'hFF, 8'h01, 1'b1, 2'b00, "signed lt ff<01");
    run_req(8'hFF, 8'h01, 1'b0, 2'b00, "unsigned lt ff<01");
    run_req(8'h5A, 8'h5A, 1'b0, 2'b10, "eq 5a");
    run_req(8'h5A, 8'h5A, 1'b0, 2'b11, "ne 5a");
    run_req(8'h80, 8'h00, 1'b0, 2'b11, "early ne 80");
    run_req(8'h80, 8'h7F, 1'b1, 2'b01, "signed le 80<=7f");
    run_req(8'h7F, 8'h7F, 1'b1, 2'b01, "signed le 7f");
    run_req(8'h7F, 8'h7F, 1'b1, 2'b00, "signed lt 7f");
    run_req(8'h01, 8'h03, 1'b0, 2'b00, "last chunk lt");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? ra : 8'($urandom);
      if (i % 8 == 1) rb = ra ^ 8'h01;
      run_req(ra, rb, 1'($urandom), 2'($urandom), $sformatf("rand%0d", i));
    end

    // Backpressure: result held, new request ignored while DONE.
    out_ready = 1'b0;
    a = 8'h12; b = 8'h34; is_signed = 1'b0; op = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 30) begin
      step();
      cyc++;
    end
    chk(32'(out_valid), 32'd1, "bp out_valid");
    chk(32'(y), 32'd1, "bp y");
    held_y = ref_y(8'h12, 8'h34, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 8'hFF; b = 8'h00; op = 2'b00;
      step();
      chk(32'(out_valid), 32'd1, "bp hold out_valid");
      chk(32'(y), 32'(held_y), "bp hold y");
      chk(32'(in_ready), 32'd0, "bp hold in_ready");
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk(32'(out_valid), 32'd0, "bp accept on first edge");
    chk(32'(in_ready), 32'd1, "bp idle after accept");
    step();
    chk(32'(out_valid), 32'd0, "bp no phantom result");

    // Reset in cycle 2 of an LT request.
    a = 8'h10; b = 8'h20; is_signed = 1'b0; op = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    chk(32'(out_valid), 32'd0, "rst mid-run out_valid");
    step();
    chk(32'(out_valid), 32'd0, "rst held out_valid");
    chk(32'(in_ready), 32'd0, "rst held in_ready");
    rst = 1'b0;
    step();
    chk(32'(in_ready), 32'd1, "in_ready after rst falls");
    for (int i = 0; i < 6; i++) begin
      chk(32'(out_valid), 32'd0, "no result from aborted request");
      step();
    end
    run_req(8'hC3, 8'h3C, 1'b1, 2'b00, "after abort signed lt");
    run_req(8'hC3, 8'h3C, 1'b0, 2'b00, "after abort unsigned lt");

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
